// File: rtl/aes_spi_block_bridge_pkg.sv
// Shared constants and FSM state type for the AES block <-> 16-bit SPI bridge.
package aes_spi_block_bridge_pkg;

  localparam int WORD_W    = 16;
  localparam int NUM_WORDS = 8;
  localparam int BLK_W     = WORD_W * NUM_WORDS;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ISSUE   = 3'd1,
    ST_WAIT    = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_GAP     = 3'd4,
    ST_FINISH  = 3'd5
  } state_e;

endpackage

// File: rtl/aes_word_mux.sv
// Combinational block-to-word selector: word idx of a packed block, LSB word first.
module aes_word_mux #(
  parameter int WORD_W = aes_spi_block_bridge_pkg::WORD_W,
  parameter int BLK_W  = aes_spi_block_bridge_pkg::BLK_W,
  parameter int IDX_W  = $clog2(BLK_W / WORD_W)
) (
  input  logic [BLK_W-1:0]  blk,
  input  logic [IDX_W-1:0]  idx,
  output logic [WORD_W-1:0] word
);

  // Pick slice [WORD_W*idx +: WORD_W]
  always_comb begin
    word = blk[idx*WORD_W +: WORD_W];
  end

endmodule

// File: rtl/aes_spi_block_bridge.sv
// Splits a 128-bit AES block into eight 16-bit SPI words (LSB word first),
// issues each to the SPI master, and reassembles the received words.
// Optional DONE watchdog and sticky timeout_err port: define SPI_TIMEOUT_EN.
module aes_spi_block_bridge #(
  parameter int WORD_W         = aes_spi_block_bridge_pkg::WORD_W,
  parameter int NUM_WORDS      = aes_spi_block_bridge_pkg::NUM_WORDS
`ifdef SPI_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 64
`endif
) (
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic [WORD_W*NUM_WORDS-1:0] blk_in,
  input  logic                        blk_valid,
  output logic                        blk_ready,
  output logic [WORD_W-1:0]           spi_data_in,
  output logic                        spi_data_valid,
  input  logic                        spi_done,
  input  logic [WORD_W-1:0]           spi_data_out,
  output logic [WORD_W*NUM_WORDS-1:0] rx_blk,
  output logic                        rx_valid,
  output logic                        busy
`ifdef SPI_TIMEOUT_EN
  , output logic                      timeout_err
`endif
);

  import aes_spi_block_bridge_pkg::*;

  localparam int BW    = WORD_W * NUM_WORDS;
  localparam int IDX_W = $clog2(NUM_WORDS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [BW-1:0]     tx_buf_q, tx_buf_d;
  logic [BW-1:0]     rx_blk_q, rx_blk_d;
  logic [WORD_W-1:0] spi_data_in_q, spi_data_in_d;

  logic [BW-1:0]     mux_blk;
  logic [IDX_W-1:0]  mux_idx;
  logic [WORD_W-1:0] mux_word;

`ifdef SPI_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] wd_q, wd_d;
  logic            timeout_err_q, timeout_err_d;
`endif

  // Word 0 is loaded straight from blk_in on accept so ISSUE can drive it
  // from a register; later words come from the latched tx buffer.
  always_comb begin
    mux_blk = (state_q == ST_IDLE) ? blk_in : tx_buf_q;
    mux_idx = (state_q == ST_IDLE) ? '0     : idx_q;
  end

  aes_word_mux #(
    .WORD_W (WORD_W),
    .BLK_W  (BW),
    .IDX_W  (IDX_W)
  ) u_word_mux (
    .blk  (mux_blk),
    .idx  (mux_idx),
    .word (mux_word)
  );

  // State and datapath registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      idx_q         <= '0;
      tx_buf_q      <= '0;
      rx_blk_q      <= '0;
      spi_data_in_q <= '0;
`ifdef SPI_TIMEOUT_EN
      wd_q          <= '0;
      timeout_err_q <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      tx_buf_q      <= tx_buf_d;
      rx_blk_q      <= rx_blk_d;
      spi_data_in_q <= spi_data_in_d;
`ifdef SPI_TIMEOUT_EN
      wd_q          <= wd_d;
      timeout_err_q <= timeout_err_d;
`endif
    end
  end

  // Next-state and next-datapath logic
  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    tx_buf_d      = tx_buf_q;
    rx_blk_d      = rx_blk_q;
    spi_data_in_d = spi_data_in_q;
`ifdef SPI_TIMEOUT_EN
    wd_d          = wd_q;
    timeout_err_d = timeout_err_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (blk_valid) begin
          tx_buf_d      = blk_in;
          idx_d         = '0;
          spi_data_in_d = mux_word;
          state_d       = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        state_d = ST_WAIT;
`ifdef SPI_TIMEOUT_EN
        wd_d    = '0;
`endif
      end
      ST_WAIT: begin
        if (spi_done) begin
          state_d = ST_CAPTURE;
`ifdef SPI_TIMEOUT_EN
        end else if (wd_q == WD_W'(TIMEOUT_CYCLES - 1)) begin
          timeout_err_d = 1'b1;
          state_d       = ST_IDLE;
        end else begin
          wd_d = wd_q + 1'b1;
`endif
        end
      end
      ST_CAPTURE: begin
        rx_blk_d[idx_q*WORD_W +: WORD_W] = spi_data_out;
        if (idx_q == LAST_IDX) begin
          state_d = ST_FINISH;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = ST_GAP;
        end
      end
      ST_GAP: begin
        spi_data_in_d = mux_word;
        state_d       = ST_ISSUE;
      end
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Moore outputs decoded from the state register
  always_comb begin
    blk_ready      = (state_q == ST_IDLE);
    busy           = (state_q != ST_IDLE);
    spi_data_valid = (state_q == ST_ISSUE);
    rx_valid       = (state_q == ST_FINISH);
    spi_data_in    = spi_data_in_q;
    rx_blk         = rx_blk_q;
`ifdef SPI_TIMEOUT_EN
    timeout_err    = timeout_err_q;
`endif
  end

endmodule

// File: doc/aes_spi_block_bridge.md
Name: aes_spi_block_bridge

Overview:
- Upstream feeder for the 16-bit SPI master: accepts one 128-bit AES block and splits it into eight 16-bit words.
- Issues each word to the master with a data_valid pulse and waits for DONE.
- Captures the master's received word and reassembles the eight received words into a 128-bit block for the AES core.
- Sits between the AES datapath and the SPI master.

Parameters:
- WORD_W, 16, SPI transfer word width; must equal the master's 16-bit frame.
- NUM_WORDS, 8, words per block; block width = WORD_W*NUM_WORDS = 128.
- TIMEOUT_CYCLES, 64, per-word DONE watchdog limit; only used when SPI_TIMEOUT_EN is defined.

Ports:
- clock  in  1  system clock; the SPI master shares it.
- reset_n  in  1  asynchronous active-low reset.
- blk_in  in  128  block to transmit.
- blk_valid  in  1  blk_in is valid; accepted when blk_valid && blk_ready.
- blk_ready  out  1  bridge is idle and can accept a block.
- spi_data_in  out  16  word to master DATA_IN.
- spi_data_valid  out  1  one-cycle start pulse to master data_valid.
- spi_done  in  1  master DONE.
- spi_data_out  in  16  master DATA_OUT.
- rx_blk  out  128  reassembled received block.
- rx_valid  out  1  one-cycle pulse; rx_blk is valid.
- busy  out  1  high from block accept until rx_valid, or until abort.
- timeout_err  out  1  sticky error flag; exists only with SPI_TIMEOUT_EN.

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE, word index=0.
  - All outputs 0 except blk_ready=1.
  - rx_blk and spi_data_in cleared to 0.
- Word order is LSB first: word k = blk_in[16k+15:16k], transmitted k=0..7.
- The received word for index k is written to rx_blk[16k+15:16k].
- IDLE:
  - blk_ready=1.
  - On blk_valid, latch blk_in into the tx buffer, set idx=0, set busy=1, go to ISSUE.
  - blk_ready drops the cycle after acceptance.
- ISSUE:
  - Drive spi_data_in=word[idx] and pulse spi_data_valid=1 for exactly one cycle, then go to WAIT.
  - spi_data_in is held stable until the next ISSUE.
- WAIT:
  - On spi_done==1, go to CAPTURE.
  - spi_done is a 1-cycle pulse; it must not be missed or double-counted.
  - A spi_done seen in any other state is ignored.
- CAPTURE:
  - The master updates DATA_OUT on the DONE edge, so spi_data_out is sampled here, one cycle after done.
  - Write the sampled word to rx_blk slot idx.
  - If idx==NUM_WORDS-1, go to FINISH.
  - Otherwise idx++ and go to GAP.
- GAP:
  - One idle cycle so the master returns to IDLE before the next data_valid. Then go to ISSUE.
- FINISH:
  - Pulse rx_valid=1 for one cycle, clear busy, go to IDLE.
  - rx_blk holds its value until the next FINISH.
- Latency: accept to rx_valid = 1 + 8*(1 issue + master frame + 1 capture + 1 gap) - 1 cycles. The bench measures this; it must be identical for every block.
- blk_valid while busy: ignored, because blk_ready=0. No queuing.
- blk_valid in the same cycle as rx_valid: not accepted. blk_ready rises the cycle after FINISH.
- Reset mid-transfer: state returns to IDLE immediately and no rx_valid is generated. The master's own CS recovery is outside this block.
- The word index is 3 bits and must not wrap past NUM_WORDS-1.

Optional Feature:
- Macro: SPI_TIMEOUT_EN.
- Defined:
  - A watchdog counter runs in WAIT and is cleared on entering WAIT.
  - If it reaches TIMEOUT_CYCLES without spi_done: set timeout_err=1 (sticky until reset), clear busy, go to IDLE, no rx_valid.
  - A partially written rx_blk is left as-is.
- Not defined:
  - No counter and no timeout_err port.
  - WAIT waits indefinitely.

Decomposition:
- Shared package holds:
  - Constants WORD_W=16, NUM_WORDS=8, BLK_W=128.
  - State encoding IDLE/ISSUE/WAIT/CAPTURE/GAP/FINISH as a 3-bit localparam set.
- One sub-module: aes_word_mux. It is combinational 128→16 word selection by idx, reused later by the receive-side demux tests.
- The FSM, capture register and watchdog stay in the top module.

Test Plan:
- Loopback: reset, then blk_in=0x00112233445566778899AABBCCDDEEFF, blk_valid for 1 cycle, master MISO tied to MOSI.
  - spi_data_in sequence is 0xEEFF, 0xCCDD, …, 0x0011.
  - Exactly 8 data_valid pulses.
  - rx_valid once, with rx_blk equal to blk_in.
- Back-to-back: second block 0xFFFF…0000 presented with blk_valid held high across the first transfer.
  - Accepted only after blk_ready returns.
  - Two rx_valid pulses with correct blocks.
  - No word interleaving.
- MISO tied to 1:
  - rx_blk=0xFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF.
  - Latency equals the computed constant.
- reset_n asserted during word 3:
  - All outputs return to reset values asynchronously.
  - No rx_valid.
  - A new block after release completes correctly.
- With SPI_TIMEOUT_EN: stub master that never asserts done.
  - timeout_err=1 exactly TIMEOUT_CYCLES=64 cycles after entering WAIT.
  - busy=0 and blk_ready=1 the cycle after.
- Spurious spi_done pulse while IDLE: no state change, no rx_valid, blk_ready stays 1.
